// File: rtl/spi_rom_loader_pkg.sv
// Shared command codes and FSM state encoding for the SPI ROM download writer.
package spi_rom_loader_pkg;

  localparam logic [7:0] CMD_FILE_TX     = 8'h53;
  localparam logic [7:0] CMD_FILE_TX_DAT = 8'h54;
  localparam logic [7:0] CMD_FILE_INDEX  = 8'h55;
  localparam logic [7:0] TX_START        = 8'hFF;
  localparam logic [7:0] TX_END          = 8'h00;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_CMD     = 3'd1,
    ST_TX_ARG  = 3'd2,
    ST_IDX_ARG = 3'd3,
    ST_DATA    = 3'd4,
    ST_SKIP    = 3'd5
  } state_t;

endpackage

// File: rtl/spi_byte_rx.sv
// Oversampling SPI byte receiver: synchronises SCK/SS/DI into clk_sys and assembles MSB-first bytes.
module spi_byte_rx (
  input  logic       clk_sys,
  input  logic       reset,
  input  logic       sck_i,
  input  logic       ss_n_i,
  input  logic       di_i,
  output logic [7:0] byte_o,
  output logic       byte_valid_o,
  output logic       frame_active_o
);

  logic [1:0] sck_sync_q;
  logic [1:0] ss_sync_q;
  logic [1:0] di_sync_q;
  logic       sck_prev_q;
  logic [2:0] bit_cnt_q;
  logic [7:0] shift_q;
  logic       byte_valid_q;
  logic       sck_rise;

  assign sck_rise = sck_sync_q[1] & ~sck_prev_q;

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      sck_sync_q   <= 2'b00;
      ss_sync_q    <= 2'b11;  // deselected, so no frame is seen while the sync chain refills
      di_sync_q    <= 2'b00;
      sck_prev_q   <= 1'b0;
      bit_cnt_q    <= 3'd0;
      shift_q      <= 8'h00;
      byte_valid_q <= 1'b0;
    end else begin
      sck_sync_q   <= {sck_sync_q[0], sck_i};
      ss_sync_q    <= {ss_sync_q[0], ss_n_i};
      di_sync_q    <= {di_sync_q[0], di_i};
      sck_prev_q   <= sck_sync_q[1];
      byte_valid_q <= 1'b0;
      if (ss_sync_q[1]) begin
        bit_cnt_q <= 3'd0;
      end else if (sck_rise) begin
        shift_q      <= {shift_q[6:0], di_sync_q[1]};
        bit_cnt_q    <= bit_cnt_q + 3'd1;
        byte_valid_q <= (bit_cnt_q == 3'd7);
      end
    end
  end

  assign byte_o         = shift_q;
  assign byte_valid_o   = byte_valid_q;
  assign frame_active_o = ~ss_sync_q[1];

endmodule

// File: rtl/spi_rom_loader.sv
// ROM download writer: decodes SS2 file-transfer frames into dn_* byte writes.
// Optional ROM_CHECKSUM_EN adds the dn_csum XOR checksum port.
// Strobe semantics: dn_wr is a single-cycle write with dn_addr/dn_data valid; no back-pressure.
module spi_rom_loader
  import spi_rom_loader_pkg::*;
#(
  parameter int                 ADDR_W     = 16,
  parameter logic [ADDR_W-1:0]  START_ADDR = '0
) (
  input  logic              clk_sys,
  input  logic              reset,
  input  logic              SPI_SCK,
  input  logic              SPI_SS2,
  input  logic              SPI_DI,
  output logic [ADDR_W-1:0] dn_addr,
  output logic [7:0]        dn_data,
  output logic              dn_wr,
  output logic              dn_ld,
  output logic [7:0]        dn_index,
`ifdef ROM_CHECKSUM_EN
  output logic [7:0]        dn_csum,
`endif
  output state_t            dbg_state
);

  localparam logic [ADDR_W-1:0] ADDR_ONE = 1;

  logic [7:0]        rx_byte;
  logic              rx_valid;
  logic              frame_active;

  state_t            state_q;
  logic [ADDR_W-1:0] addr_q;
  logic [7:0]        data_q;
  logic              wr_q;
  logic              ld_q;
  logic [7:0]        index_q;
`ifdef ROM_CHECKSUM_EN
  logic [7:0]        csum_q;
`endif

  spi_byte_rx u_rx (
    .clk_sys        (clk_sys),
    .reset          (reset),
    .sck_i          (SPI_SCK),
    .ss_n_i         (SPI_SS2),
    .di_i           (SPI_DI),
    .byte_o         (rx_byte),
    .byte_valid_o   (rx_valid),
    .frame_active_o (frame_active)
  );

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state_q <= ST_IDLE;
      addr_q  <= START_ADDR;
      data_q  <= 8'h00;
      wr_q    <= 1'b0;
      ld_q    <= 1'b0;
      index_q <= 8'h00;
`ifdef ROM_CHECKSUM_EN
      csum_q  <= 8'h00;
`endif
    end else begin
      wr_q <= 1'b0;
      // Address advances the cycle after each strobe; start command below overrides it.
      if (wr_q) addr_q <= addr_q + ADDR_ONE;
      if (!frame_active) begin
        state_q <= ST_IDLE;
      end else begin
        case (state_q)
          ST_IDLE: state_q <= ST_CMD;
          ST_CMD: if (rx_valid) begin
            case (rx_byte)
              CMD_FILE_TX:     state_q <= ST_TX_ARG;
              CMD_FILE_TX_DAT: state_q <= ST_DATA;
              CMD_FILE_INDEX:  state_q <= ST_IDX_ARG;
              default:         state_q <= ST_SKIP;
            endcase
          end
          ST_TX_ARG: if (rx_valid) begin
            if (rx_byte == TX_START) begin
              ld_q   <= 1'b1;
              addr_q <= START_ADDR;
`ifdef ROM_CHECKSUM_EN
              csum_q <= 8'h00;
`endif
            end else if (rx_byte == TX_END) begin
              ld_q <= 1'b0;
            end
            state_q <= ST_SKIP;
          end
          ST_IDX_ARG: if (rx_valid) begin
            if (!ld_q) index_q <= rx_byte;
            state_q <= ST_SKIP;
          end
          ST_DATA: if (rx_valid && ld_q) begin
            data_q <= rx_byte;
            wr_q   <= 1'b1;
`ifdef ROM_CHECKSUM_EN
            csum_q <= csum_q ^ rx_byte;
`endif
          end
          ST_SKIP: state_q <= ST_SKIP;
          default: state_q <= ST_IDLE;
        endcase
      end
    end
  end

  assign dn_addr   = addr_q;
  assign dn_data   = data_q;
  assign dn_wr     = wr_q;
  assign dn_ld     = ld_q;
  assign dn_index  = index_q;
`ifdef ROM_CHECKSUM_EN
  assign dn_csum   = csum_q;
`endif
  assign dbg_state = state_q;

endmodule

// File: tb/tb_spi_rom_loader.sv
// Bench for spi_rom_loader: 16-bit and 4-bit address instances driven by the same SPI stream.
module tb_spi_rom_loader;
  import spi_rom_loader_pkg::*;

  logic clk_sys = 1'b0;
  logic reset   = 1'b1;
  logic SPI_SCK = 1'b0;
  logic SPI_SS2 = 1'b1;
  logic SPI_DI  = 1'b0;

  logic [15:0] addr16;
  logic [3:0]  addr4;
  logic [7:0]  data16, data4, index16, index4;
  logic        wr16, wr4, ld16, ld4;
  state_t      dbg16, dbg4;
`ifdef ROM_CHECKSUM_EN
  logic [7:0]  csum16, csum4;
`endif

  always #5 clk_sys = ~clk_sys;

  spi_rom_loader u_dut16 (
    .clk_sys(clk_sys), .reset(reset), .SPI_SCK(SPI_SCK), .SPI_SS2(SPI_SS2), .SPI_DI(SPI_DI),
    .dn_addr(addr16), .dn_data(data16), .dn_wr(wr16), .dn_ld(ld16), .dn_index(index16),
`ifdef ROM_CHECKSUM_EN
    .dn_csum(csum16),
`endif
    .dbg_state(dbg16)
  );

  spi_rom_loader #(.ADDR_W(4)) u_dut4 (
    .clk_sys(clk_sys), .reset(reset), .SPI_SCK(SPI_SCK), .SPI_SS2(SPI_SS2), .SPI_DI(SPI_DI),
    .dn_addr(addr4), .dn_data(data4), .dn_wr(wr4), .dn_ld(ld4), .dn_index(index4),
`ifdef ROM_CHECKSUM_EN
    .dn_csum(csum4),
`endif
    .dbg_state(dbg4)
  );

  int n_pass  = 0;
  int n_total = 0;

  // Reference model: download state as the ARM protocol defines it.
  logic [23:0] exp_q16[$];
  logic [11:0] exp_q4[$];
  logic [7:0]  frm[$];
  bit          m_ld    = 1'b0;
  int          m_addr  = 0;
  logic [7:0]  m_index = 8'h00;
  logic [7:0]  m_data  = 8'h00;
  logic [7:0]  m_csum  = 8'h00;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic model_reset();
    m_ld = 1'b0; m_addr = 0; m_index = 8'h00; m_data = 8'h00; m_csum = 8'h00;
  endtask

  task automatic model_frame();
    if (frm.size() == 0) return;
    case (frm[0])
      8'h53: if (frm.size() >= 2) begin
        if (frm[1] == 8'hFF) begin m_ld = 1'b1; m_addr = 0; m_csum = 8'h00; end
        else if (frm[1] == 8'h00) m_ld = 1'b0;
      end
      8'h54: for (int i = 1; i < frm.size(); i++) begin
        if (m_ld) begin
          exp_q16.push_back({16'(m_addr % 65536), frm[i]});
          exp_q4.push_back({4'(m_addr % 16), frm[i]});
          m_data = frm[i];
          m_csum = m_csum ^ frm[i];
          m_addr++;
        end
      end
      8'h55: if (frm.size() >= 2 && !m_ld) m_index = frm[1];
      default: ;
    endcase
  endtask

  task automatic spi_bits(input logic [7:0] b, input int n);
    for (int i = 7; i > 7 - n; i--) begin
      @(negedge clk_sys); SPI_DI = b[i];
      repeat (3) @(negedge clk_sys);
      SPI_SCK = 1'b1;
      repeat (3) @(negedge clk_sys);
      SPI_SCK = 1'b0;
    end
  endtask

  task automatic send_frame();
    model_frame();
    @(negedge clk_sys); SPI_SS2 = 1'b0;
    repeat (4) @(negedge clk_sys);
    foreach (frm[i]) spi_bits(frm[i], 8);
    repeat (4) @(negedge clk_sys);
    SPI_SS2 = 1'b1;
    repeat (8) @(negedge clk_sys);
  endtask

  task automatic check_state(input string tag);
    chk({tag, "_ld16"},    32'(ld16),    32'(m_ld));
    chk({tag, "_ld4"},     32'(ld4),     32'(m_ld));
    chk({tag, "_addr16"},  32'(addr16),  32'(m_addr % 65536));
    chk({tag, "_addr4"},   32'(addr4),   32'(m_addr % 16));
    chk({tag, "_index"},   32'(index16), 32'(m_index));
    chk({tag, "_data"},    32'(data16),  32'(m_data));
    chk({tag, "_pending"}, 32'(exp_q16.size() + exp_q4.size()), 32'd0);
`ifdef ROM_CHECKSUM_EN
    chk({tag, "_csum16"},  32'(csum16),  32'(m_csum));
    chk({tag, "_csum4"},   32'(csum4),   32'(m_csum));
`endif
  endtask

  // Write monitor: each strobe must match the next expected (addr,data) pair.
  always @(negedge clk_sys) begin
    logic [23:0] e16;
    logic [11:0] e4;
    if (wr16) begin
      chk("wr16_expected", 32'(exp_q16.size() != 0), 32'd1);
      if (exp_q16.size() != 0) begin
        e16 = exp_q16.pop_front();
        chk("wr16_addr", 32'(addr16), 32'(e16[23:8]));
        chk("wr16_data", 32'(data16), 32'(e16[7:0]));
      end
    end
    if (wr4) begin
      chk("wr4_expected", 32'(exp_q4.size() != 0), 32'd1);
      if (exp_q4.size() != 0) begin
        e4 = exp_q4.pop_front();
        chk("wr4_addr", 32'(addr4), 32'(e4[11:8]));
        chk("wr4_data", 32'(data4), 32'(e4[7:0]));
      end
    end
  end

  initial begin
    #3000000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

  initial begin
    int n;
    logic [7:0] b;
    repeat (3) @(negedge clk_sys);
    reset = 1'b0;
    @(negedge clk_sys);
    check_state("reset");
    chk("reset_state", 32'(dbg16), 32'(ST_IDLE));
    chk("reset_wr", 32'(wr16), 32'd0);

    // Basic download: start, three bytes, end.
    frm = '{8'h53, 8'hFF}; send_frame();
    check_state("start1");
    frm = '{8'h54, 8'h11, 8'h22, 8'h33}; send_frame();
    check_state("data1");
    frm = '{8'h53, 8'h00}; send_frame();
    check_state("end1");

    // Index set before download, frozen during it.
    frm = '{8'h55, 8'h07}; send_frame();
    check_state("idx7");
    frm = '{8'h53, 8'hFF}; send_frame();
    frm = '{8'h55, 8'h09}; send_frame();
    check_state("idx_frozen");
    frm = '{8'h54, 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255))}; send_frame();
    frm = '{8'h53, 8'h00}; send_frame();
    check_state("end2");

    // Data while not loading is dropped.
    frm = '{8'h54, 8'hAA}; send_frame();
    check_state("drop");

    // Seventeen bytes: the 4-bit instance wraps back to address 0.
    frm = '{8'h53, 8'hFF}; send_frame();
    frm = '{8'h54};
    for (int i = 0; i < 17; i++) frm.push_back(8'($urandom_range(0, 255)));
    send_frame();
    check_state("wrap");
    frm = '{8'h53, 8'h00}; send_frame();

    // Partial byte discarded when SS2 rises mid-byte; download continues in the next frame.
    frm = '{8'h53, 8'hFF}; send_frame();
    @(negedge clk_sys); SPI_SS2 = 1'b0;
    repeat (4) @(negedge clk_sys);
    spi_bits(8'h54, 8);
    spi_bits(8'($urandom_range(0, 255)), 5);
    repeat (4) @(negedge clk_sys); SPI_SS2 = 1'b1;
    repeat (8) @(negedge clk_sys);
    check_state("partial");
    frm = '{8'h54, 8'h5A}; send_frame();
    check_state("after_partial");
    frm = '{8'h53, 8'h00}; send_frame();

    // Checksum of a known block.
    frm = '{8'h53, 8'hFF}; send_frame();
    frm = '{8'h54, 8'h01, 8'h02, 8'h04}; send_frame();
    frm = '{8'h53, 8'h00}; send_frame();
    check_state("csum");

    // Random frame mix.
    for (int k = 0; k < 10; k++) begin
      case ($urandom_range(0, 4))
        0: frm = '{8'h53, 8'hFF};
        1: frm = '{8'h53, ($urandom_range(0, 1) != 0) ? 8'h00 : 8'($urandom_range(1, 254))};
        2: frm = '{8'h55, 8'($urandom_range(0, 255))};
        3: begin
          frm = '{8'h54};
          n = $urandom_range(1, 6);
          for (int i = 0; i < n; i++) frm.push_back(8'($urandom_range(0, 255)));
        end
        default: begin
          b = 8'($urandom_range(0, 255));
          if (b >= 8'h53 && b <= 8'h55) b = 8'h00;
          frm = '{b, 8'hFF, 8'($urandom_range(0, 255))};
        end
      endcase
      send_frame();
      check_state($sformatf("rnd%0d", k));
    end

    // Reset after two of four data bytes.
    frm = '{8'h53, 8'hFF}; send_frame();
    frm = '{8'h54, 8'h01, 8'h02};
    model_frame();
    @(negedge clk_sys); SPI_SS2 = 1'b0;
    repeat (4) @(negedge clk_sys);
    foreach (frm[i]) spi_bits(frm[i], 8);
    repeat (6) @(negedge clk_sys);
    reset = 1'b1;
    @(negedge clk_sys);
    reset = 1'b0;
    model_reset();
    chk("rst_mid_ld", 32'(ld16), 32'd0);
    chk("rst_mid_addr", 32'(addr16), 32'd0);
    spi_bits(8'h04, 8);
    spi_bits(8'h08, 8);
    repeat (4) @(negedge clk_sys); SPI_SS2 = 1'b1;
    repeat (8) @(negedge clk_sys);
    check_state("rst_mid");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
